data_ram_be: RTL and testbench
==============================

DATA_RAM_BE -- requirements
Module: data_ram_be

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8 (elaboration error otherwise).
REQ-002 Parameter ADDR_WIDTH, default 10, word-address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit fill value written by the clear sequencer.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 clear_req  input  1  one-cycle request to re-run memory clear.
REQ-007 req_valid  input  1  access request present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  word address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 req_be  input  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
REQ-013 rsp_valid  output  1  read data valid, one-cycle pulse per accepted read.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data, registered.
REQ-015 busy  output  1  clear sequencer active.

Function
REQ-016 FSM states CLEAR and IDLE only; encoding free.
REQ-017 Request accepted iff req_valid && req_ready at a rising edge.
REQ-018 req_ready = (state == IDLE) && !clear_req, combinational; no other dependence.
REQ-019 Accepted write: each byte lane with req_be[i]=1 updated from req_wdata; lanes with req_be[i]=0 keep old contents; req_be all-zero = no change, still accepted.
REQ-020 Accepted write produces no response; rsp_valid low the following cycle.
REQ-021 Accepted read at edge N: rsp_valid=1 and rsp_rdata=mem[req_addr] after edge N+1's preceding edge, i.e. visible in cycle N+1 (1-cycle latency); rsp_valid deasserts next cycle unless another read accepted.
REQ-022 rsp_rdata holds its last value while rsp_valid=0.
REQ-023 Back-to-back requests one per cycle at full throughput; read directly after write to same address returns the newly written data.
REQ-024 CLEAR: write CLEAR_VALUE to mem[cnt] each cycle, cnt counts 0..DEPTH-1; after writing DEPTH-1 go to IDLE; exactly DEPTH cycles in CLEAR.
REQ-025 busy = (state == CLEAR).
REQ-026 IDLE with clear_req=1 -> CLEAR next cycle, cnt reset to 0; any request in that cycle not accepted.
REQ-027 clear_req during CLEAR: ignored; counter not restarted.
REQ-028 A read response pending when clear begins still delivered with pre-clear data.
REQ-029 No request accepted, no response generated, while in CLEAR.
REQ-030 Counter width ADDR_WIDTH+1 or wrap-safe equivalent; no wrap past DEPTH-1.

Reset
REQ-031 rst_n sampled low: state=CLEAR, cnt=0, rsp_valid=0, rsp_rdata=0, busy=1, req_ready=0 from the next cycle.
REQ-032 rst_n low held: stays in CLEAR with cnt=0; sequence starts counting the first cycle rst_n is high.
REQ-033 Reset mid-clear or mid-operation: same as REQ-031; in-flight read response discarded.
REQ-034 Memory contents undefined only until first clear completes; no simulation file I/O in this block.

Verification
REQ-035 Reset 2 cycles, release -> busy=1 for exactly 1024 cycles, req_ready rises cycle 1024; read addr 0x3FF returns 0x00000000.
REQ-036 Write 0xDEADBEEF be=1111 addr 5, then write 0x00001234 be=0011 addr 5, read addr 5 -> rsp_rdata=0xDEAD1234 one cycle after accept.
REQ-037 Write addr 7 = 0xA5A5A5A5 then immediately read addr 7 next cycle -> 0xA5A5A5A5; continuous read stream addr 0..15 -> 16 consecutive rsp_valid pulses in order.
REQ-038 clear_req with req_valid=1 read in same cycle -> request not accepted, busy=1 next cycle for 1024 cycles, prior-written addr 5 reads 0x00000000 afterwards.
REQ-039 rst_n low at cycle 300 of a clear -> cnt restarts, busy remains 1 for full 1024 cycles after release.
REQ-040 Parameter set DATA_WIDTH=64, ADDR_WIDTH=4, CLEAR_VALUE=all-ones -> 16-cycle clear, reads return 0xFFFFFFFFFFFFFFFF, 8-lane byte enable merge correct.

Source files
------------

// File: rtl/data_ram_be_if.sv
// Request/response bus of the byte-enable data RAM.
// The slave modport is the RAM side; the master modport is the requester side.
interface data_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/data_ram_be.sv
// Single-port word RAM with per-byte write enables, a registered read port
// with one cycle of latency, and a clear sequencer that fills every word
// with CLEAR_VALUE after reset or on request.
module data_ram_be #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req,
    output logic          busy,
    data_ram_be_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    generate
        if (DATA_WIDTH % 8 != 0) begin : g_width_check
            $error("data_ram_be: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic                  clear_last;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    // Requests are only taken while idle and not in the cycle a clear is asked for.
    assign bus.req_ready = (state == S_IDLE) && !clear_req;
    assign busy          = (state == S_CLEAR);
    assign accept        = bus.req_valid && bus.req_ready;
    // Writes are also held off while rst_n is low so a request racing reset cannot land.
    assign wr_en         = accept && bus.req_we && rst_n;
    assign rd_en         = accept && !bus.req_we;
    // An all-ones counter is the last word; the counter then wraps to 0 harmlessly.
    assign clear_last    = (state == S_CLEAR) && (cnt == '1);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // State register: reset forces the clear sequence.
    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: CLEAR runs to the last word, IDLE leaves on clear_req.
    // NOTE: state_next gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: if (clear_last) state_next = S_IDLE;
            S_IDLE:  if (clear_req)  state_next = S_CLEAR;
            default: state_next = S_CLEAR;
        endcase
    end

    // Clear address counter: held at 0 outside CLEAR, so every clear starts at word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_CLEAR) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Memory write port: clear sequencer or byte-lane merge of an accepted write.
    // NOTE: the array has no reset; its contents are defined by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_CLEAR) begin
                mem[cnt] <= CLEAR_VALUE;
            end else if (wr_en) begin
                for (int i = 0; i < LANES; i++) begin
                    if (bus.req_be[i]) begin
                        mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Registered read port: one pulse per accepted read, data held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rd_en;
            if (rd_en) begin
                rsp_rdata_q <= mem[bus.req_addr];
            end
        end
    end
endmodule

// File: tb/tb_data_ram_be.sv
// Scoreboard bench for data_ram_be: a 32x1024 instance with zero fill and a
// 64x16 instance with all-ones fill, driven from one stimulus thread and
// checked by one monitor per instance.
module tb_data_ram_be;
    logic clk = 1'b0;
    logic rst_n;
    logic clr0, clr1;
    logic busy0, busy1;

    data_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus0();
    data_ram_be_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4))  bus1();

    data_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .CLEAR_VALUE(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_req(clr0), .busy(busy0), .bus(bus0)
    );

    data_ram_be #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .CLEAR_VALUE({64{1'b1}})) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_req(clr1), .busy(busy1), .bus(bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m0 [1024];
    logic [63:0] m1 [16];
    logic [31:0] last0 = '0;
    logic [63:0] last1 = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction

    task automatic fill(input int sel);
        if (sel == 0) foreach (m0[i]) m0[i] = 32'h0;
        else          foreach (m1[i]) m1[i] = {64{1'b1}};
    endtask

    task automatic set_clr(input int sel, input logic v);
        if (sel == 0) clr0 = v; else clr1 = v;
    endtask

    // Cycle counter advanced on the active edge; all checking happens on negedges.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            last0 = '0;
            last1 = '0;
        end
    end

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            check("rsp0_valid", 64'(bus0.rsp_valid), 64'd1);
            check("rsp0_data", 64'(bus0.rsp_rdata), e.data);
            last0 = e.data[31:0];
        end else if (bus0.rsp_valid) begin
            check("rsp0_spurious", 64'(bus0.rsp_valid), 64'd0);
        end else begin
            check("rsp0_hold", 64'(bus0.rsp_rdata), 64'(last0));
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            check("rsp1_valid", 64'(bus1.rsp_valid), 64'd1);
            check("rsp1_data", bus1.rsp_rdata, e.data);
            last1 = e.data;
        end else if (bus1.rsp_valid) begin
            check("rsp1_spurious", 64'(bus1.rsp_valid), 64'd0);
        end else begin
            check("rsp1_hold", bus1.rsp_rdata, last1);
        end
    end

    // One bus cycle: entered just after a posedge, returns just after the next.
    task automatic do_op(input int sel, input bit valid, input bit we, input int addr,
                         input logic [63:0] wd, input logic [7:0] be, input bit clr,
                         output bit acc);
        logic [63:0] nv;
        if (sel == 0) begin
            bus0.req_valid = valid; bus0.req_we = we; bus0.req_addr = addr[9:0];
            bus0.req_wdata = wd[31:0]; bus0.req_be = be[3:0];
        end else begin
            bus1.req_valid = valid; bus1.req_we = we; bus1.req_addr = addr[3:0];
            bus1.req_wdata = wd; bus1.req_be = be;
        end
        set_clr(sel, clr);
        @(negedge clk);
        acc = valid && get_ready(sel);
        if (acc) begin
            if (sel == 0) begin
                if (we) begin
                    nv = merge({32'h0, m0[addr]}, wd, {4'h0, be[3:0]});
                    m0[addr] = nv[31:0];
                end else begin
                    q0.push_back('{data: {32'h0, m0[addr]}, due: cyc + 1});
                end
            end else begin
                if (we) m1[addr] = merge(m1[addr], wd, be);
                else    q1.push_back('{data: m1[addr], due: cyc + 1});
            end
        end
        if (clr) fill(sel);
        @(posedge clk);
        #1;
        if (sel == 0) bus0.req_valid = 1'b0; else bus1.req_valid = 1'b0;
        set_clr(sel, 1'b0);
    endtask

    // Counts busy cycles until idle (bounded), optionally pulsing clear_req mid-clear.
    task automatic wait_clear(input int sel, input int exp_n, input int pulse_at);
        int n = 0;
        bit done = 0;
        for (int k = 0; k < 5000 && !done; k++) begin
            @(negedge clk);
            if (get_busy(sel)) n++;
            else done = 1;
            set_clr(sel, (pulse_at > 0) && (n == pulse_at) && get_busy(sel));
        end
        set_clr(sel, 1'b0);
        check($sformatf("clear%0d_done", sel), 64'(done), 64'd1);
        check($sformatf("clear%0d_cycles", sel), 64'(n), 64'(exp_n));
        check($sformatf("clear%0d_ready_after", sel), 64'(get_ready(sel)), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int hold);
        rst_n = 1'b0;
        fill(0);
        fill(1);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
            wait_clear(0, 1024, 0);
            wait_clear(1, 16, 0);
        join
    endtask

    initial begin
        bit acc;
        bit v;
        int a;
        logic [63:0] wd;
        logic [7:0]  be;

        rst_n = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_be = '0;
        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_be = '0;
        fill(0);
        fill(1);

        // Reset state, held for two cycles.
        @(posedge clk);
        @(negedge clk);
        check("rst_busy0", 64'(busy0), 64'd1);
        check("rst_ready0", 64'(bus0.req_ready), 64'd0);
        check("rst_rsp_valid0", 64'(bus0.rsp_valid), 64'd0);
        check("rst_rdata0", 64'(bus0.rsp_rdata), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd1);
        check("rst_rdata1", bus1.rsp_rdata, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
            wait_clear(0, 1024, 0);
            wait_clear(1, 16, 0);
        join

        // Top word after the initial clear.
        do_op(0, 1, 0, 1023, 0, 0, 0, acc);
        check("rd_3ff_acc", 64'(acc), 64'd1);

        // Byte-lane merge on the 32-bit instance.
        do_op(0, 1, 1, 5, 64'hDEADBEEF, 8'hF, 0, acc);
        do_op(0, 1, 1, 5, 64'h00001234, 8'h3, 0, acc);
        do_op(0, 1, 1, 5, 64'h55555555, 8'h0, 0, acc);
        check("be_zero_acc", 64'(acc), 64'd1);
        do_op(0, 1, 0, 5, 0, 0, 0, acc);

        // Read directly after write, then a full-rate read stream.
        do_op(0, 1, 1, 7, 64'hA5A5A5A5, 8'hF, 0, acc);
        do_op(0, 1, 0, 7, 0, 0, 0, acc);
        for (int i = 0; i < 16; i++) begin
            do_op(0, 1, 0, i, 0, 0, 0, acc);
            check("stream_acc", 64'(acc), 64'd1);
        end

        // Read pending when clear starts, then clear_req colliding with a read.
        do_op(0, 1, 0, 5, 0, 0, 0, acc);
        do_op(0, 1, 0, 5, 0, 0, 1, acc);
        check("clr_blocks_req", 64'(acc), 64'd0);
        wait_clear(0, 1024, 500);
        do_op(0, 1, 0, 5, 0, 0, 0, acc);

        // Reset partway through a clear restarts the full sequence.
        do_op(0, 1, 1, 9, 64'h12345678, 8'hF, 0, acc);
        do_op(0, 0, 0, 0, 0, 0, 1, acc);
        repeat (300) @(negedge clk);
        check("mid_clear_busy", 64'(busy0), 64'd1);
        check("mid_clear_ready", 64'(bus0.req_ready), 64'd0);
        @(posedge clk);
        #1;
        pulse_reset(2);
        do_op(0, 1, 0, 9, 0, 0, 0, acc);

        // A read presented while reset is sampled produces no response.
        bus0.req_valid = 1; bus0.req_we = 0; bus0.req_addr = 10'd7;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        bus0.req_valid = 0;
        @(negedge clk);
        check("rst_drop_rsp", 64'(bus0.rsp_valid), 64'd0);
        check("rst_drop_rdata", 64'(bus0.rsp_rdata), 64'd0);
        check("rst_hold_busy", 64'(busy0), 64'd1);
        pulse_reset(1);

        // Randomized traffic on the 32-bit instance, including the top word.
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 4) != 0);
            a  = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 15);
            wd = {$urandom, $urandom};
            be = 8'($urandom_range(0, 15));
            do_op(0, v, 1'($urandom_range(0, 1)), a, wd, be, 0, acc);
            check("rand0_acc", 64'(acc), 64'(v));
        end

        // 64-bit instance: all-ones fill, 8-lane merge, randomized traffic.
        for (int i = 0; i < 16; i++) do_op(1, 1, 0, i, 0, 0, 0, acc);
        do_op(1, 1, 1, 3, 64'h0123456789ABCDEF, 8'hA5, 0, acc);
        do_op(1, 1, 0, 3, 0, 0, 0, acc);
        for (int i = 0; i < 200; i++) begin
            v  = ($urandom_range(0, 4) != 0);
            wd = {$urandom, $urandom};
            be = 8'($urandom_range(0, 255));
            do_op(1, v, 1'($urandom_range(0, 1)), $urandom_range(0, 15), wd, be, 0, acc);
            check("rand1_acc", 64'(acc), 64'(v));
        end
        do_op(1, 0, 0, 0, 0, 0, 1, acc);
        wait_clear(1, 16, 5);
        do_op(1, 1, 0, 3, 0, 0, 0, acc);

        repeat (3) @(posedge clk);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
